// File: rtl/fcvt_int_seq.sv
// Three-stage IEEE-754 float to integer converter (RISC-V FCVT.W/WU.S, FCVT.L/LU.D).
// Stage 1 unpacks, stage 2 aligns and rounds, stage 3 range-checks, negates and raises flags.
module fcvt_int_seq #(
  parameter int BUS_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [2:0]           rm,
  input  logic                 is_unsigned,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 flag_nv,
  output logic                 flag_nx
);
  localparam int W      = BUS_WIDTH;
  localparam int EW     = (W == 64) ? 11 : 8;
  localparam int MW     = (W == 64) ? 52 : 23;
  localparam int BIAS   = (1 << (EW - 1)) - 1;
  localparam int XW     = EW + 2;
  localparam int SH     = $clog2(W);
  localparam int STAGES = 3;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0, RM_RTZ = 3'd1, RM_RDN = 3'd2, RM_RUP = 3'd3, RM_RMM = 3'd4
  } rm_e;

  typedef struct packed {
    logic                 s;
    logic signed [XW-1:0] e;
    logic [MW:0]          sig;
    logic                 nan;
    logic                 inf;
    logic                 den;
    rm_e                  rmode;
    logic                 uns;
  } s1_t;

  typedef struct packed {
    logic         s;
    logic [W:0]   r;
    logic         inexact;
    logic         ovf;
    logic         nan;
    logic         inf;
    logic         uns;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic            rdy_q;
  logic            advance;
  logic            take;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [W-1:0]    res_d;
  logic            nv_d, nx_d;

  assign advance   = ~out_valid | out_ready;
  assign in_ready  = rdy_q & advance;
  assign take      = in_valid & in_ready;
  assign out_valid = vld_pipe[STAGES];

  // Stage 1: unpack and classify
  logic [EW-1:0] ex;
  logic [MW-1:0] mf;
  assign ex = in1[W-2 -: EW];
  assign mf = in1[MW-1:0];

  always_comb begin
    s1_d       = '0;
    s1_d.s     = in1[W-1];
    s1_d.e     = $signed({2'b00, ex}) - $signed(XW'(BIAS));
    s1_d.sig   = {|ex, mf};
    s1_d.nan   = (&ex) & (|mf);
    s1_d.inf   = (&ex) & ~(|mf);
    s1_d.den   = ~(|ex);
    s1_d.rmode = (rm > 3'd4) ? RM_RNE : rm_e'(rm);
    s1_d.uns   = is_unsigned;
  end

  // Stage 2: align significand to the integer point, then round
  logic [W+MW-1:0] shl;
  logic [W-1:0]    ipart;
  logic            g, t, inc, ovf;

  always_comb begin
    shl   = '0;
    ipart = '0;
    g     = 1'b0;
    t     = 1'b0;
    ovf   = ~s1_q.den & ~s1_q.e[XW-1] & (s1_q.e[XW-2:0] >= (XW-1)'(W));
    if (s1_q.den) begin
      t = |s1_q.sig;
    end else if (s1_q.e[XW-1]) begin
      // Magnitude below 1: only e = -1 puts the leading one in the guard position
      g = (s1_q.e == '1);
      t = (s1_q.e == '1) ? |s1_q.sig[MW-1:0] : 1'b1;
    end else if (!ovf) begin
      shl   = {{(W-1){1'b0}}, s1_q.sig} << s1_q.e[SH-1:0];
      ipart = shl[MW +: W];
      g     = shl[MW-1];
      t     = |shl[MW-2:0];
    end
    case (s1_q.rmode)
      RM_RNE:  inc = g & (t | ipart[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1_q.s & (g | t);
      RM_RUP:  inc = ~s1_q.s & (g | t);
      RM_RMM:  inc = g;
      default: inc = g & (t | ipart[0]);
    endcase
    s2_d         = '0;
    s2_d.s       = s1_q.s;
    s2_d.r       = {1'b0, ipart} + (W+1)'(inc);
    s2_d.inexact = g | t;
    s2_d.ovf     = ovf;
    s2_d.nan     = s1_q.nan;
    s2_d.inf     = s1_q.inf;
    s2_d.uns     = s1_q.uns;
  end

  // Stage 3: range check, saturate, negate
  logic [W-1:0] maxp, minn;
  assign maxp = s2_q.uns ? {W{1'b1}} : {1'b0, {(W-1){1'b1}}};
  assign minn = s2_q.uns ? {W{1'b0}} : {1'b1, {(W-1){1'b0}}};

  always_comb begin
    res_d = '0;
    nv_d  = 1'b0;
    if (s2_q.nan) begin
      res_d = maxp;
      nv_d  = 1'b1;
    end else if (s2_q.inf | s2_q.ovf) begin
      res_d = s2_q.s ? minn : maxp;
      nv_d  = 1'b1;
    end else if (s2_q.uns) begin
      if (!s2_q.s) begin
        if (s2_q.r[W]) begin
          res_d = maxp;
          nv_d  = 1'b1;
        end else begin
          res_d = s2_q.r[W-1:0];
        end
      end else begin
        nv_d = |s2_q.r;
      end
    end else if (!s2_q.s) begin
      if (s2_q.r[W] | s2_q.r[W-1]) begin
        res_d = maxp;
        nv_d  = 1'b1;
      end else begin
        res_d = s2_q.r[W-1:0];
      end
    end else begin
      // Exactly 2^(W-1) negates to itself, which is the legal minimum
      if (s2_q.r[W] | (s2_q.r[W-1] & (|s2_q.r[W-2:0]))) begin
        res_d = minn;
        nv_d  = 1'b1;
      end else begin
        res_d = -s2_q.r[W-1:0];
      end
    end
    nx_d = s2_q.inexact & ~nv_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q    <= 1'b0;
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      out      <= '0;
      flag_nv  <= 1'b0;
      flag_nx  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (advance) begin
        vld_pipe <= {vld_pipe[STAGES-1:1], take};
        s1_q     <= s1_d;
        s2_q     <= s2_d;
        out      <= res_d;
        flag_nv  <= nv_d;
        flag_nx  <= nx_d;
      end
    end
  end
endmodule

// File: tb/tb_fcvt_int_seq.sv
// Directed bench for fcvt_int_seq at BUS_WIDTH=32: rounding, saturation, flags, stall and reset.
module tb_fcvt_int_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [2:0]   rm = 3'd0;
  logic         is_unsigned = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         flag_nv, flag_nx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  // Each entry is {out, nv, nx}
  logic [W+1:0] res_q[$];
  int           res_cyc[$];

  fcvt_int_seq #(.BUS_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in1(in1),
    .rm(rm), .is_unsigned(is_unsigned), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flag_nv(flag_nv), .flag_nx(flag_nx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (out_valid && out_ready) begin
      res_q.push_back({out, flag_nv, flag_nx});
      res_cyc.push_back(cyc);
    end

  task automatic send(input logic [W-1:0] d, input logic [2:0] r, input logic u);
    bit ok;
    in1 = d; rm = r; is_unsigned = u; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) begin
        acc_cyc  = cyc;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    n_checks++; n_fail++;
    $display("FAIL send_timeout: operand %h not accepted within 50 cycles", d);
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 100 && res_q.size() < n; i++) @(posedge clk);
    #1;
    n_checks++;
    if (res_q.size() < n) begin
      n_fail++;
      $display("FAIL result_count: got %0d results, required %0d", res_q.size(), n);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #3;
    n_checks++;
    if ({out_valid, out, flag_nv, flag_nx} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b out=%h nv=%b nx=%b, required all zero",
               out_valid, out, flag_nv, flag_nx);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_pi_latency;
    res_q.delete(); res_cyc.delete();
    send(32'h40490FDB, 3'd0, 1'b0);
    wait_results(1);
    if (res_q.size() >= 1) begin
      n_checks++;
      if (res_q[0] !== {32'h00000003, 2'b01}) begin
        n_fail++;
        $display("FAIL pi_rne: got %h required %h", res_q[0], {32'h00000003, 2'b01});
      end
      // Count edges including the accepting one
      n_checks++;
      if (res_cyc[0] - acc_cyc + 1 !== 3) begin
        n_fail++;
        $display("FAIL pi_latency: got %0d cycles required 3", res_cyc[0] - acc_cyc + 1);
      end
    end
  endtask

  task automatic test_rounding_back_to_back;
    logic [W+1:0] exp_v [6];
    exp_v = '{{32'hFFFFFFFE, 2'b01}, {32'hFFFFFFFE, 2'b01}, {32'hFFFFFFFD, 2'b01},
              {32'hFFFFFFFE, 2'b01}, {32'hFFFFFFFD, 2'b01}, {32'hFFFFFFFE, 2'b01}};
    res_q.delete(); res_cyc.delete();
    for (int r = 0; r < 6; r++) send(32'hC0200000, (r == 5) ? 3'd6 : 3'(r), 1'b0);
    wait_results(6);
    for (int i = 0; i < 6 && i < res_q.size(); i++) begin
      n_checks++;
      if (res_q[i] !== exp_v[i]) begin
        n_fail++;
        $display("FAIL round_m2p5_rm%0d: got %h required %h", i, res_q[i], exp_v[i]);
      end
      if (i > 0) begin
        n_checks++;
        if (res_cyc[i] !== res_cyc[i-1] + 1) begin
          n_fail++;
          $display("FAIL round_consecutive_%0d: got cycle %0d required %0d",
                   i, res_cyc[i], res_cyc[i-1] + 1);
        end
      end
    end
  endtask

  task automatic test_signed_bounds;
    logic [W-1:0] vin [4];
    logic [W+1:0] exp_v [4];
    vin   = '{32'hCF000000, 32'h4F000000, 32'h7FC00000, 32'hFF800000};
    exp_v = '{{32'h80000000, 2'b00}, {32'h7FFFFFFF, 2'b10},
              {32'h7FFFFFFF, 2'b10}, {32'h80000000, 2'b10}};
    res_q.delete(); res_cyc.delete();
    for (int i = 0; i < 4; i++) send(vin[i], 3'd0, 1'b0);
    wait_results(4);
    for (int i = 0; i < 4 && i < res_q.size(); i++) begin
      n_checks++;
      if (res_q[i] !== exp_v[i]) begin
        n_fail++;
        $display("FAIL signed_%h: got %h required %h", vin[i], res_q[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_unsigned;
    logic [W-1:0] vin [4];
    logic [2:0]   vrm [4];
    logic [W+1:0] exp_v [4];
    vin   = '{32'hBF800000, 32'hBE800000, 32'h4F800000, 32'h4F7FFFFF};
    vrm   = '{3'd0, 3'd1, 3'd0, 3'd0};
    exp_v = '{{32'h00000000, 2'b10}, {32'h00000000, 2'b01},
              {32'hFFFFFFFF, 2'b10}, {32'hFFFFFF00, 2'b00}};
    res_q.delete(); res_cyc.delete();
    for (int i = 0; i < 4; i++) send(vin[i], vrm[i], 1'b1);
    wait_results(4);
    for (int i = 0; i < 4 && i < res_q.size(); i++) begin
      n_checks++;
      if (res_q[i] !== exp_v[i]) begin
        n_fail++;
        $display("FAIL unsigned_%h: got %h required %h", vin[i], res_q[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] vin [4];
    vin = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    res_q.delete(); res_cyc.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(vin[i], 3'd0, 1'b0);
      end
      begin
        int k = 0;
        while (!out_valid && k < 50) begin @(negedge clk); k++; end
        n_checks++;
        if (!out_valid) begin
          n_fail++;
          $display("FAIL stall_first_valid: got out_valid=%b required 1", out_valid);
        end
        for (int i = 0; i < 5; i++) begin
          n_checks++;
          if ({out_valid, in_ready, out} !== {1'b1, 1'b0, 32'h00000001}) begin
            n_fail++;
            $display("FAIL stall_hold_%0d: got v=%b rdy=%b out=%h required v=1 rdy=0 out=00000001",
                     i, out_valid, in_ready, out);
          end
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_results(4);
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (res_q.size() !== 4) begin
      n_fail++;
      $display("FAIL stall_count: got %0d results required 4", res_q.size());
    end
    for (int i = 0; i < 4 && i < res_q.size(); i++) begin
      n_checks++;
      if (res_q[i] !== {W'(i + 1), 2'b00}) begin
        n_fail++;
        $display("FAIL stall_order_%0d: got %h required %h", i, res_q[i], {W'(i + 1), 2'b00});
      end
    end
  endtask

  task automatic test_reset_mid;
    res_q.delete(); res_cyc.delete();
    send(32'h3F800000, 3'd0, 1'b0);
    send(32'h40000000, 3'd0, 1'b0);
    @(posedge clk); #2;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre_valid: got %b required 1", out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_clear: got v=%b out=%h required v=0 out=00000000", out_valid, out);
    end
    res_q.delete(); res_cyc.delete();
    #9 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (res_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rstmid_no_ghost: got %0d results required 0", res_q.size());
    end
    send(32'h41200000, 3'd0, 1'b0);
    wait_results(1);
    if (res_q.size() >= 1) begin
      n_checks++;
      if (res_q[0] !== {32'h0000000A, 2'b00}) begin
        n_fail++;
        $display("FAIL rstmid_ten: got %h required %h", res_q[0], {32'h0000000A, 2'b00});
      end
      n_checks++;
      if (res_cyc[0] - acc_cyc + 1 !== 3) begin
        n_fail++;
        $display("FAIL rstmid_latency: got %0d cycles required 3", res_cyc[0] - acc_cyc + 1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_pi_latency;
    test_rounding_back_to_back;
    test_signed_bounds;
    test_unsigned;
    test_backpressure;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fcvt_int_seq.md
Name: fcvt_int_seq

Overview:
- Pipelined floating-point to integer converter: IEEE-754 binary64 or binary32 operand in, signed or unsigned integer of the same width out.
- Implements RISC-V FCVT.W/WU.S and FCVT.L/LU.D semantics, including all rounding modes, saturation and NV/NX flags.
- Sits in the FPU beside the integer-to-float converter and shares that block's BUS_WIDTH convention.
- 3-stage pipeline with valid/ready on both sides.

Parameters:
- BUS_WIDTH, 64, operand/result width; 64 selects binary64 (E=11, M=52, BIAS=1023), 32 selects binary32 (E=8, M=23, BIAS=127). Any other value is unsupported.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand valid
- in_ready  output  1  converter can accept operand this cycle
- in1  input  BUS_WIDTH  floating-point operand
- rm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE
- is_unsigned  input  1  1 = unsigned result (WU/LU), 0 = signed
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  BUS_WIDTH  integer result
- flag_nv  output  1  invalid operation, valid with out_valid
- flag_nx  output  1  inexact, valid with out_valid

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0, out/flag_nv/flag_nx = 0, out_valid = 0. In-flight operations are discarded and no result emerges for them. in_ready is 1 from the first edge after release.
- Handshake:
  - advance = ~out_valid | out_ready; in_ready = advance.
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - When advance = 0, all stages hold and out/flags stay stable. Once out_valid rises, it stays high until accepted.
  - Bubbles propagate; no compaction is required.
- Latency: 3 cycles from input transfer to out_valid with out_ready held 1. Throughput is 1 result per cycle.
- Stage 1 (unpack):
  - Capture S, E, M, rm, is_unsigned.
  - Classify NaN (E all ones, M≠0), Inf (E all ones, M=0), zero/denormal (E=0), normal.
  - Significand = {1,M} for normal; denormals are treated as magnitude < 1.
  - Unbiased exponent e = E − BIAS.
- Stage 2 (shift and round):
  - If e ≥ BUS_WIDTH, set the overflow pre-flag.
  - Otherwise right-align the significand to the integer point, keeping integer part I, guard bit G and sticky T (OR of all remaining bits).
  - Denormal/zero: I=0, G=0, T=(M≠0).
  - Round-up increment inc:
    - RNE = G&(T|I[0])
    - RTZ = 0
    - RDN = S&(G|T)
    - RUP = ~S&(G|T)
    - RMM = G
  - R = I + inc, one bit wider than BUS_WIDTH. inexact = G|T.
- Stage 3 (range check, negate, flags):
  - Signed:
    - Range is [−2^(W−1), 2^(W−1)−1].
    - Positive R > 2^(W−1)−1 → out=0x7F..F, NV=1.
    - Negative R > 2^(W−1) → out=0x80..0, NV=1.
    - Otherwise out = S ? −R : R.
  - Unsigned:
    - Positive R > 2^W−1 → all ones, NV=1.
    - Negative with R≠0 → out=0, NV=1.
    - Negative with R=0 → out=0, NV=0.
  - NaN → max positive (signed 0x7F..F, unsigned all ones), NV=1.
  - +Inf → max positive, NV=1. −Inf → signed 0x80..0 / unsigned 0, NV=1.
  - NX = inexact & ~NV. NV and NX are never both 1.
  - ±0 input → out=0, no flags.
- The overflow pre-flag behaves as out-of-range in stage 3, including exactly ±2^(W−1) boundary handling.

Test Plan (BUS_WIDTH=32, out_ready=1 unless stated):
- 0x40490FDB (3.14159), signed, RNE → out=0x00000003, NX=1, NV=0, out_valid exactly 3 cycles after accept.
- 0xC0200000 (−2.5), signed, rm=RNE/RTZ/RDN/RUP/RMM back-to-back → 0xFFFFFFFE, 0xFFFFFFFE, 0xFFFFFFFD, 0xFFFFFFFE, 0xFFFFFFFD, all NX=1; five consecutive out_valid cycles.
- Signed boundaries:
  - 0xCF000000 (−2^31) → 0x80000000, no flags.
  - 0x4F000000 (2^31) → 0x7FFFFFFF, NV=1.
  - 0x7FC00000 (NaN) → 0x7FFFFFFF, NV=1.
  - 0xFF800000 (−Inf) → 0x80000000, NV=1.
- Unsigned:
  - 0xBF800000 (−1.0) → 0, NV=1.
  - 0xBE800000 (−0.25) RTZ → 0, NX=1, NV=0.
  - 0x4F800000 (2^32) → 0xFFFFFFFF, NV=1.
  - 0x4F7FFFFF → 0xFFFFFF00, no flags.
- Backpressure: stream 4 operands (1.0, 2.0, 3.0, 4.0) with out_ready low for 5 cycles after first out_valid → in_ready low while stalled, out holds 0x00000001 stable, then results 1, 2, 3, 4 in order, none lost or duplicated.
- Reset mid-operation: accept 2 operands, assert rst_n low for 1 cycle asynchronously mid-period → out_valid=0 and out=0 immediately, no result emerges after release, next operand 0x41200000 (10.0) → 0x0000000A after 3 cycles.
